debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
- Parametrised N-channel debouncer for push-buttons and switches.
- Each channel has an input synchroniser, a symmetric stability filter for press and release, one-cycle press/release strobes and a long-press strobe.
- Sits between raw board inputs and control FSMs; it supersedes the single-channel press-only debouncer.

Parameters:
- N, 4, number of independent channels (≥1).
- SYNC, 2, synchroniser flip-flop stages per channel (≥2).
- DEL, 50, consecutive clock edges a new level must be stable before btn_o follows (≥1).
- LONG, 1000, clock edges btn_o must stay high before long_o pulses; 0 disables long-press detection.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- btn_i  in  N  raw asynchronous button levels, active-high.
- btn_o  out N  debounced level per channel.
- press_o  out N  one-cycle strobe when btn_o goes 0->1.
- release_o  out N  one-cycle strobe when btn_o goes 1->0.
- long_o  out N  one-cycle strobe after btn_o has been high for LONG edges.

Behaviour:
- Reset (async, rst_i=1): all synchroniser stages, counters, btn_o, press_o, release_o and long_o are 0. Reset mid-count discards all progress. First filter evaluation happens on the first edge after rst_i falls.
- Clock is assumed running; each channel is fully independent with no shared state.
- Synchroniser: s = btn_i passed through SYNC flops. A btn_i level set up before edge k appears on s after edge k+SYNC-1.
- Stability counter cnt is ceil(log2(DEL+1)) bits. Each edge:
  - s == btn_o: cnt <= 0.
  - s != btn_o and cnt < DEL-1: cnt <= cnt+1.
  - s != btn_o and cnt == DEL-1: btn_o <= s, cnt <= 0, and press_o (s=1) or release_o (s=0) is 1 for exactly that cycle.
- Any return of s to btn_o before DEL consecutive mismatches restarts the count from 0. Glitches shorter than DEL cycles never reach btn_o.
- Latency: a clean step on btn_i before edge k changes btn_o at edge k+SYNC+DEL-1. The strobe is registered alongside it.
- Strobes are registered, default 0, and never longer than one cycle. press_o and release_o are never both 1 on the same channel.
- Long-press counter hold is ceil(log2(LONG+1)) bits, active only if LONG>0:
  - btn_o == 0: hold <= 0.
  - btn_o == 1 and hold < LONG: hold <= hold+1; on the edge where hold becomes LONG, long_o = 1 for that cycle.
  - hold saturates at LONG, so long_o fires at most once per press.
  - long_o rises LONG edges after press_o.
- Release after a long press produces a normal release_o; the next press re-arms long_o.
- LONG=0: hold logic is not generated and long_o is tied 0.
- Simultaneous activity on several channels is fully independent; all outputs may be asserted in the same cycle.

Test Plan:
- N=4, SYNC=2, DEL=4, LONG=10. Reset asserted mid-simulation -> all outputs 0 immediately and asynchronously (no clock needed); after release, btn_o remains 0 with btn_i=0.
- Clean step btn_i[0] 0->1 before edge 0 -> btn_o[0]=1 and press_o[0]=1 after edge 5, press_o[0]=0 after edge 6. Other channels stay 0.
- Bounce on btn_i[1]: 1 for 3 cycles, 0 for 1, 1 for 2, 0 steady -> btn_o[1] stays 0 and no strobes.
- Hold btn_i[2]=1 for 30 cycles, then 0 -> press_o[2] after edge 5, long_o[2] single pulse 10 edges later, no second long_o. release_o[2] fires SYNC+DEL edges after the fall.
- All four channels stepped on the same edge with different hold times -> identical press timing on each channel; releases occur independently per channel.
- Reset pulse while cnt=3 mid-press on channel 3 -> cnt cleared; after reset, the held input needs a full SYNC+DEL edges before press_o[3].

Source files
------------

// File: rtl/debounce_multi.sv
// N-channel push-button debouncer: per-channel synchroniser, symmetric stability
// filter, one-cycle press/release strobes and an optional long-press strobe.
module debounce_multi #(
    parameter int N    = 4,
    parameter int SYNC = 2,
    parameter int DEL  = 50,
    parameter int LONG = 1000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] btn_i,
    output logic [N-1:0] btn_o,
    output logic [N-1:0] press_o,
    output logic [N-1:0] release_o,
    output logic [N-1:0] long_o
);

    localparam int CW = $clog2(DEL + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEL - 1);

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_ch
            logic [SYNC-1:0] r_sync;
            logic [CW-1:0]   r_cnt;
            logic            r_btn;
            logic            r_press;
            logic            r_release;
            logic            w_s;

            assign w_s = r_sync[SYNC-1];

            // The counter only runs while the synchronised level disagrees with
            // the debounced one; any agreement restarts the stability window.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_sync    <= '0;
                    r_cnt     <= '0;
                    r_btn     <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    r_sync    <= {r_sync[SYNC-2:0], btn_i[g]};
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    if (w_s == r_btn) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt     <= '0;
                        r_btn     <= w_s;
                        r_press   <= w_s;
                        r_release <= ~w_s;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign btn_o[g]     = r_btn;
            assign press_o[g]   = r_press;
            assign release_o[g] = r_release;

            if (LONG > 0) begin : g_long
                localparam int HW = $clog2(LONG + 1);
                localparam logic [HW-1:0] HOLD_MAX = HW'(LONG);
                logic [HW-1:0] r_hold;
                logic          r_long;

                // Saturating at HOLD_MAX keeps long_o to a single pulse per press.
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) begin
                        r_hold <= '0;
                        r_long <= 1'b0;
                    end else if (!r_btn) begin
                        r_hold <= '0;
                        r_long <= 1'b0;
                    end else if (r_hold != HOLD_MAX) begin
                        r_hold <= r_hold + 1'b1;
                        r_long <= (r_hold == HOLD_MAX - 1'b1);
                    end else begin
                        r_long <= 1'b0;
                    end
                end

                assign long_o[g] = r_long;
            end else begin : g_no_long
                assign long_o[g] = 1'b0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed vector table, hand-written corner sequences
// and randomized bouncing inputs checked against a window-based reference model.
module tb_debounce_multi;
    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int DEL  = 4;
    localparam int LONG = 10;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [N-1:0] btn_i = '0;
    logic [N-1:0] btn_o, press_o, release_o, long_o;

    debounce_multi #(.N(N), .SYNC(SYNC), .DEL(DEL), .LONG(LONG)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .btn_i     (btn_i),
        .btn_o     (btn_o),
        .press_o   (press_o),
        .release_o (release_o),
        .long_o    (long_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: history of input samples per edge since reset. The
    // debounced level flips when the DEL most recent synchronised samples all
    // disagree with it; long fires LONG edges after a press still held.
    logic [N-1:0] hist[$];
    int           edge_no;
    logic [N-1:0] m_lvl, m_press, m_rel, m_long;
    int           press_edge[N];

    function automatic logic [N-1:0] s_at(int idx);
        if (idx < 0) return '0;
        return hist[idx];
    endfunction

    task automatic model_reset();
        hist.delete();
        edge_no = 0;
        m_lvl   = '0;
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        for (int c = 0; c < N; c++) press_edge[c] = -100000;
    endtask

    task automatic model_edge();
        logic [N-1:0] smp;
        hist.push_back(btn_i);
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        for (int c = 0; c < N; c++) begin
            logic old_lvl;
            bit   all_diff;
            old_lvl  = m_lvl[c];
            all_diff = 1'b1;
            for (int k = 0; k < DEL; k++) begin
                smp = s_at(edge_no - SYNC - k);
                if (smp[c] == old_lvl) all_diff = 1'b0;
            end
            if (old_lvl && (edge_no - press_edge[c] == LONG)) m_long[c] = 1'b1;
            if (all_diff) begin
                m_lvl[c] = ~old_lvl;
                if (!old_lvl) begin
                    m_press[c]    = 1'b1;
                    press_edge[c] = edge_no;
                end else begin
                    m_rel[c] = 1'b1;
                end
            end
        end
        edge_no++;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", name, edge_no - 1, act, exp);
        end
    endtask

    // One clock edge: advance the model (if out of reset), then compare #1 later.
    task automatic tick();
        @(posedge clk_i);
        if (!rst_i) model_edge();
        #1;
        check("btn_o", 32'(btn_o), 32'(m_lvl));
        check("press_o", 32'(press_o), 32'(m_press));
        check("release_o", 32'(release_o), 32'(m_rel));
        check("long_o", 32'(long_o), 32'(m_long));
    endtask

    // Called at +1 after an edge: asserts reset between edges, checks outputs
    // clear without a clock edge, then releases reset away from the edge.
    task automatic async_reset(int hold_edges);
        #1;
        rst_i = 1'b1;
        model_reset();
        #1;
        check("rst_btn_o", 32'(btn_o), 32'h0);
        check("rst_press_o", 32'(press_o), 32'h0);
        check("rst_release_o", 32'(release_o), 32'h0);
        check("rst_long_o", 32'(long_o), 32'h0);
        repeat (hold_edges) tick();
        rst_i = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] btn;
        logic [N-1:0] e_btn;
        logic [N-1:0] e_press;
        logic [N-1:0] e_rel;
        logic [N-1:0] e_long;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int press_e, long_e, long_n, rel_e;
        int p_e[N];
        int r_e[N];
        int fall_e[N];
        int rem[N];
        logic [N-1:0] cur;

        // Clean step on channel 0: press at edge SYNC+DEL-1 = 5, one-cycle strobe.
        for (int i = 0; i < 8; i++) begin
            tbl[i].btn     = 4'b0001;
            tbl[i].e_btn   = (i >= 5) ? 4'b0001 : 4'b0000;
            tbl[i].e_press = (i == 5) ? 4'b0001 : 4'b0000;
            tbl[i].e_rel   = 4'b0000;
            tbl[i].e_long  = 4'b0000;
        end

        model_reset();
        repeat (3) tick();
        rst_i = 1'b0;
        repeat (4) tick();

        async_reset(2);
        for (int i = 0; i < 8; i++) begin
            btn_i = tbl[i].btn;
            tick();
            check("tbl_btn_o", 32'(btn_o), 32'(tbl[i].e_btn));
            check("tbl_press_o", 32'(press_o), 32'(tbl[i].e_press));
            check("tbl_release_o", 32'(release_o), 32'(tbl[i].e_rel));
            check("tbl_long_o", 32'(long_o), 32'(tbl[i].e_long));
        end
        btn_i = '0;
        repeat (10) tick();

        // Bounce on channel 1 never reaches DEL consecutive samples.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 7; i++) begin
                btn_i[1] = (i < 3 || i == 4 || i == 5);
                tick();
                check("bounce_ch1", 32'(btn_o[1] | press_o[1] | release_o[1]), 32'h0);
            end
        end
        btn_i = '0;
        repeat (8) tick();
        check("bounce_ch1_final", 32'(btn_o[1]), 32'h0);

        // Long hold on channel 2: press at 5, long at 15 only, release at 35.
        async_reset(1);
        press_e = -1; long_e = -1; long_n = 0; rel_e = -1;
        for (int i = 0; i < 42; i++) begin
            btn_i = (i < 30) ? 4'b0100 : 4'b0000;
            tick();
            if (press_o[2]) press_e = edge_no - 1;
            if (long_o[2]) begin long_e = edge_no - 1; long_n++; end
            if (release_o[2]) rel_e = edge_no - 1;
        end
        check("hold_press_edge", 32'(press_e), 32'd5);
        check("hold_long_edge", 32'(long_e), 32'd15);
        check("hold_long_count", 32'(long_n), 32'd1);
        check("hold_release_edge", 32'(rel_e), 32'd35);

        // All channels stepped together, released at different edges.
        async_reset(1);
        fall_e[0] = 8; fall_e[1] = 14; fall_e[2] = 20; fall_e[3] = 30;
        for (int c = 0; c < N; c++) begin p_e[c] = -1; r_e[c] = -1; end
        for (int i = 0; i < 45; i++) begin
            for (int c = 0; c < N; c++) btn_i[c] = (i < fall_e[c]);
            tick();
            for (int c = 0; c < N; c++) begin
                if (press_o[c]) p_e[c] = edge_no - 1;
                if (release_o[c]) r_e[c] = edge_no - 1;
            end
        end
        for (int c = 0; c < N; c++) begin
            check("multi_press_edge", 32'(p_e[c]), 32'd5);
            check("multi_release_edge", 32'(r_e[c]), 32'(fall_e[c] + SYNC + DEL - 1));
        end

        // Reset while channel 3 is mid-count: progress must be discarded.
        async_reset(1);
        btn_i = 4'b1000;
        repeat (5) tick();
        async_reset(2);
        press_e = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (press_o[3]) press_e = edge_no - 1;
        end
        check("rst_mid_press_edge", 32'(press_e), 32'd5);
        btn_i = '0;
        repeat (8) tick();

        // Randomized bouncing with mostly short and occasional long holds.
        for (int c = 0; c < N; c++) rem[c] = 0;
        cur = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N; c++) begin
                if (rem[c] == 0) begin
                    cur[c] = 1'($urandom_range(0, 1));
                    rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 30)
                                                         : $urandom_range(1, 6);
                end
                rem[c]--;
            end
            btn_i = cur;
            tick();
            if (i == 1500) async_reset(2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
